enabled_oscillator_bank: RTL and testbench
==========================================

Name: enabled_oscillator_bank

Overview:
Synthesizable, clocked successor to the enabled ring oscillator. It provides CHANNELS independent square-wave oscillators, each with its own enable and a programmable half-period in clk cycles. Each channel starts and stops glitch-free: no high pulse is ever truncated. Each channel also has a saturating rising-edge counter that can be read back through a select mux, so oscillation can be measured on silicon without a scope.

Parameters:
CHANNELS, 4, number of independent oscillator channels (1..16).
DIV_W, 8, width of each half-period value.
CNT_W, 16, width of each saturating edge counter.
SEL_W, 2, width of count_sel; equals max(1, clog2(CHANNELS)).

Ports:
clk  input  1  single system clock.
reset  input  1  synchronous, active-high reset.
enable  input  CHANNELS  per-channel run request; bit i controls channel i.
half_period  input  CHANNELS*DIV_W  packed half-periods; channel i uses bits [i*DIV_W +: DIV_W].
load  input  1  one-cycle strobe; latches all half_period fields into the shadow registers.
count_sel  input  SEL_W  selects which channel's edge counter appears on count_out.
count_clear  input  1  one-cycle strobe; clears the edge counter of the channel selected by count_sel.
oscillate  output  CHANNELS  oscillator outputs, registered.
running  output  CHANNELS  1 while the channel state is not IDLE, registered.
count_out  output  CNT_W  registered count of the selected channel.

Behaviour:
- Reset (synchronous, active-high):
  - outputs: oscillate=0, running=0, count_out=0.
  - internal: all states IDLE; shadow and active half-period =1; phase counters =0; edge counters =0.
  - reset asserted mid-oscillation forces oscillate=0 on the next edge, with no drain.
- Half-period:
  - load copies half_period into the shadow registers.
  - active registers take the shadow value only in IDLE or at a phase boundary (the cycle a toggle occurs), so an output phase is never shortened or stretched mid-phase.
  - An effective value of 0 is treated as 1. Period = 2*H cycles; duty cycle 50%.
- Per-channel FSM (IDLE, RUN, DRAIN):
  - IDLE: oscillate=0, phase counter=0. If enable=1 is sampled at edge t, then at t+1 the state is RUN, oscillate=1 and the active half-period is loaded from the shadow.
  - RUN: phase counter increments each cycle. When it reaches H-1: oscillate toggles, the counter resets to 0 and the active half-period is reloaded. Each level therefore holds exactly H cycles.
  - RUN with enable=0:
    - if oscillate=0, go to IDLE on the next edge; output stays 0 and the phase counter is cleared.
    - if oscillate=1, go to DRAIN.
  - DRAIN: oscillate stays 1 until the phase counter reaches H-1, then oscillate=0 and the state goes to IDLE. The total high time is exactly H cycles.
  - enable=1 again during DRAIN returns to RUN without disturbing the phase counter or output (the period continues seamlessly).
  - enable toggling while IDLE with a one-cycle pulse: the channel enters RUN and then immediately drains. The result is a single complete H-cycle high pulse.
- Edge counters:
  - Increment on each 0->1 transition of oscillate, detected on the registered output.
  - Saturate at 2^CNT_W-1; no wrap.
  - count_clear for the selected channel has priority over a simultaneous increment; the result is 0.
  - Counters are not cleared by enable changes.
- count_out:
  - Registered mux: the value visible at t+1 reflects count_sel and counter contents at t.
  - count_sel >= CHANNELS gives 0.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- Reset with enable=4'hF, half_period=all 3: hold reset 5 cycles -> oscillate=0, running=0, count_out=0 throughout; after release, all channels start 1 cycle later.
- Channel 0, H=3, enable held 60 cycles -> oscillate0=1 one cycle after enable sampled, then exact 3-high/3-low pattern. Check at every clk that the output changes only at phase boundaries (bench must fail a stuck output, unlike a level-only check); after 60 cycles the edge count = 10.
- Drain: H=4, drop enable 1 cycle after a rising toggle -> oscillate stays high 3 more cycles (4 total), then 0, running=0 the same cycle. Drop enable while low -> IDLE next cycle, no extra pulse.
- Reload: H=2 running; load H=5 mid-phase -> the current phase completes at 2 cycles and the next phase is 5 cycles. half_period=0 -> behaves as H=1 (toggle every cycle).
- Counters: CNT_W=4, H=1, run 40 cycles -> count_out saturates at 15. count_clear coinciding with a rising edge -> 0. count_sel=2 reads channel 2 with 1-cycle latency; an out-of-range select reads 0.
- Independence: ch0 H=2, ch1 H=7, ch2 disabled, ch3 enabled then disabled mid-run -> each matches its own model, with ch2 oscillate=0 and count 0.

Source files
------------

// File: rtl/enabled_oscillator_bank.sv
// enabled_oscillator_bank: per-channel glitch-free enable-gated square-wave oscillators with saturating, selectable edge counters
module enabled_oscillator_bank #(
  parameter int CHANNELS = 4,
  parameter int DIV_W = 8,
  parameter int CNT_W = 16,
  parameter int SEL_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*DIV_W-1:0] half_period,
  input  logic                      load,
  input  logic [SEL_W-1:0]          count_sel,
  input  logic                      count_clear,
  output logic [CHANNELS-1:0]       oscillate,
  output logic [CHANNELS-1:0]       running,
  output logic [CNT_W-1:0]          count_out
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  logic [CNT_W-1:0] cnt_mux [2**SEL_W];
  for (genvar c = CHANNELS; c < 2**SEL_W; c++) begin : g_pad
    assign cnt_mux[c] = '0;
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t state, state_n;
    logic osc, osc_n, osc_q, bnd;
    logic [DIV_W-1:0] phase, phase_n, shadow, active, active_n, h;
    logic [CNT_W-1:0] cnt;
    assign h = active == '0 ? DIV_W'(1) : active;
    assign bnd = phase == h - DIV_W'(1);
    always_comb begin
      state_n = state;
      osc_n = osc;
      phase_n = phase;
      active_n = active;
      if (state == IDLE) begin
        state_n = enable[i] ? RUN : IDLE;
        osc_n = enable[i];
        phase_n = '0;
        active_n = shadow;
      end else if (enable[i]) begin
        state_n = RUN;
        osc_n = bnd ? ~osc : osc;
        phase_n = bnd ? '0 : phase + DIV_W'(1);
        active_n = bnd ? shadow : active;
      end else if (!osc || bnd) begin
        state_n = IDLE;
        osc_n = 1'b0;
        phase_n = '0;
        active_n = bnd ? shadow : active;
      end else begin
        state_n = DRAIN;
        phase_n = phase + DIV_W'(1);
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        osc <= 1'b0;
        osc_q <= 1'b0;
        phase <= '0;
        shadow <= DIV_W'(1);
        active <= DIV_W'(1);
        cnt <= '0;
      end else begin
        state <= state_n;
        osc <= osc_n;
        osc_q <= osc;
        phase <= phase_n;
        active <= active_n;
        if (load) shadow <= half_period[i*DIV_W +: DIV_W];
        if (count_clear && count_sel == SEL_W'(i)) cnt <= '0;
        else if (osc && !osc_q && cnt != '1) cnt <= cnt + CNT_W'(1);
      end
    end
    assign oscillate[i] = osc;
    assign running[i] = state != IDLE;
    assign cnt_mux[i] = cnt;
  end
  always_ff @(posedge clk) count_out <= reset ? '0 : cnt_mux[count_sel];
endmodule

// File: tb/tb_enabled_oscillator_bank.sv
// tb_enabled_oscillator_bank: scoreboard bench for the oscillator bank
module tb_enabled_oscillator_bank;
  typedef struct packed {logic [3:0] osc; logic [3:0] run;} exp_t;
  logic clk, reset, load, count_clear, load2, clr2;
  logic [3:0] enable, oscillate, running;
  logic [31:0] half_period;
  logic [1:0] count_sel, sel2;
  logic [15:0] count_out;
  logic [2:0] e2, osc2, run2;
  logic [23:0] hp2;
  logic [3:0] cnt2;
  exp_t sb[$];
  logic [15:0] cq[$];
  int errors = 0;
  int checks = 0;
  enabled_oscillator_bank dut (
    .clk(clk), .reset(reset), .enable(enable), .half_period(half_period), .load(load),
    .count_sel(count_sel), .count_clear(count_clear), .oscillate(oscillate),
    .running(running), .count_out(count_out)
  );
  enabled_oscillator_bank #(.CHANNELS(3), .DIV_W(8), .CNT_W(4), .SEL_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(e2), .half_period(hp2), .load(load2),
    .count_sel(sel2), .count_clear(clr2), .oscillate(osc2), .running(run2), .count_out(cnt2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    enable = '0;
    load = 1'b0;
    count_clear = 1'b0;
    count_sel = '0;
    half_period = '0;
    e2 = '0;
    load2 = 1'b0;
    clr2 = 1'b0;
    sel2 = '0;
    hp2 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic load_hp(input logic [31:0] hp);
    half_period = hp;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic test_reset;
    exp_t e;
    do_reset();
    reset = 1'b1;
    enable = 4'hF;
    half_period = {4{8'd3}};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({oscillate, running, count_out} !== 24'h0) begin
        errors++;
        $display("FAIL reset cycle %0d: osc=%h run=%h cnt=%h expected all 0", i, oscillate, running, count_out);
      end
    end
    reset = 1'b0;
    sb.push_back('{osc: 4'hF, run: 4'hF});
    tick();
    e = sb.pop_front();
    checks++;
    if ({oscillate, running} !== e) begin
      errors++;
      $display("FAIL reset release: osc=%h run=%h expected osc=%h run=%h", oscillate, running, e.osc, e.run);
    end
  endtask
  task automatic test_run;
    exp_t e;
    do_reset();
    load_hp(32'h3);
    for (int j = 0; j < 60; j++) begin
      enable = 4'b0001;
      sb.push_back('{osc: {3'b0, ((j / 3) % 2) == 0}, run: 4'b0001});
      tick();
      e = sb.pop_front();
      checks++;
      if ({oscillate, running} !== e) begin
        errors++;
        $display("FAIL run j=%0d: osc=%h run=%h expected osc=%h run=%h", j, oscillate, running, e.osc, e.run);
      end
    end
    enable = '0;
    count_sel = 2'd0;
    tick();
    cq.push_back(16'd10);
    tick();
    checks++;
    if (count_out !== cq[0]) begin
      errors++;
      $display("FAIL run edge count: got %0d expected %0d", count_out, cq[0]);
    end
    void'(cq.pop_front());
  endtask
  task automatic test_drain;
    exp_t e;
    logic [0:9] p1;
    logic [0:11] o2, r2;
    p1 = 10'b1111000000;
    o2 = 12'b111100000000;
    r2 = 12'b111110000000;
    do_reset();
    load_hp(32'h4);
    for (int j = 0; j < 10; j++) begin
      enable = {3'b0, j == 0};
      sb.push_back('{osc: {3'b0, p1[j]}, run: {3'b0, p1[j]}});
      tick();
      e = sb.pop_front();
      checks++;
      if ({oscillate, running} !== e) begin
        errors++;
        $display("FAIL drain high j=%0d: osc=%h run=%h expected osc=%h run=%h", j, oscillate, running, e.osc, e.run);
      end
    end
    do_reset();
    load_hp(32'h4);
    for (int j = 0; j < 12; j++) begin
      enable = {3'b0, j <= 4};
      sb.push_back('{osc: {3'b0, o2[j]}, run: {3'b0, r2[j]}});
      tick();
      e = sb.pop_front();
      checks++;
      if ({oscillate, running} !== e) begin
        errors++;
        $display("FAIL drain low j=%0d: osc=%h run=%h expected osc=%h run=%h", j, oscillate, running, e.osc, e.run);
      end
    end
  endtask
  task automatic test_reload;
    exp_t e;
    logic [0:19] ro;
    ro = 20'b11000001111101010101;
    do_reset();
    load_hp(32'h2);
    for (int j = 0; j < 20; j++) begin
      enable = 4'b0001;
      load = (j == 1) || (j == 8);
      half_period = j == 1 ? 32'h5 : 32'h0;
      sb.push_back('{osc: {3'b0, ro[j]}, run: 4'b0001});
      tick();
      e = sb.pop_front();
      checks++;
      if ({oscillate, running} !== e) begin
        errors++;
        $display("FAIL reload j=%0d: osc=%h run=%h expected osc=%h run=%h", j, oscillate, running, e.osc, e.run);
      end
    end
    load = 1'b0;
  endtask
  task automatic test_counters;
    exp_t e;
    logic [15:0] x;
    do_reset();
    for (int j = 0; j < 40; j++) begin
      e2 = {j < 5, 1'b0, 1'b1};
      sb.push_back('{osc: {1'b0, j < 5 && j % 2 == 0, 1'b0, j % 2 == 0}, run: {1'b0, j < 5, 1'b0, 1'b1}});
      tick();
      e = sb.pop_front();
      checks++;
      if ({1'b0, osc2, 1'b0, run2} !== e) begin
        errors++;
        $display("FAIL counters osc j=%0d: osc=%h run=%h expected osc=%h run=%h", j, osc2, run2, e.osc, e.run);
      end
    end
    e2 = '0;
    tick();
    tick();
    tick();
    sel2 = 2'd0;
    cq.push_back(16'd15);
    tick();
    x = cq.pop_front();
    checks++;
    if ({12'b0, cnt2} !== x) begin
      errors++;
      $display("FAIL saturate: got %0d expected %0d", cnt2, x);
    end
    sel2 = 2'd2;
    cq.push_back(16'd3);
    #1;
    checks++;
    if (cnt2 !== 4'd15) begin
      errors++;
      $display("FAIL select latency: got %0d expected 15 before the edge", cnt2);
    end
    tick();
    x = cq.pop_front();
    checks++;
    if ({12'b0, cnt2} !== x) begin
      errors++;
      $display("FAIL select ch2: got %0d expected %0d", cnt2, x);
    end
    sel2 = 2'd3;
    cq.push_back(16'd0);
    tick();
    x = cq.pop_front();
    checks++;
    if ({12'b0, cnt2} !== x) begin
      errors++;
      $display("FAIL select out of range: got %0d expected %0d", cnt2, x);
    end
    do_reset();
    sel2 = 2'd1;
    for (int j = 0; j < 9; j++) begin
      e2 = {1'b0, j <= 3, 1'b0};
      clr2 = j == 3;
      cq.push_back((j == 2 || j == 3) ? 16'd1 : 16'd0);
      tick();
      x = cq.pop_front();
      checks++;
      if ({12'b0, cnt2} !== x) begin
        errors++;
        $display("FAIL clear priority j=%0d: got %0d expected %0d", j, cnt2, x);
      end
    end
    clr2 = 1'b0;
  endtask
  task automatic test_independence;
    exp_t e;
    logic [15:0] x;
    logic o3;
    int cnt_exp[4];
    cnt_exp = '{8, 3, 0, 2};
    do_reset();
    load_hp({8'd3, 8'd5, 8'd7, 8'd2});
    for (int j = 0; j < 30; j++) begin
      enable = {j < 8, 1'b0, 1'b1, 1'b1};
      o3 = ((j / 3) % 2 == 0) && (j < 8 || j / 3 == 2);
      sb.push_back('{osc: {o3, 1'b0, (j / 7) % 2 == 0, (j / 2) % 2 == 0}, run: {j < 8 || o3, 3'b011}});
      tick();
      e = sb.pop_front();
      checks++;
      if ({oscillate, running} !== e) begin
        errors++;
        $display("FAIL independence j=%0d: osc=%h run=%h expected osc=%h run=%h", j, oscillate, running, e.osc, e.run);
      end
    end
    enable = '0;
    for (int i = 0; i < 10; i++) tick();
    for (int s = 0; s < 4; s++) begin
      count_sel = 2'(s);
      cq.push_back(16'(cnt_exp[s]));
      tick();
      x = cq.pop_front();
      checks++;
      if (count_out !== x) begin
        errors++;
        $display("FAIL independence count ch%0d: got %0d expected %0d", s, count_out, x);
      end
    end
  endtask
  task automatic test_mid_reset;
    do_reset();
    load_hp({4{8'd3}});
    enable = 4'hF;
    tick();
    tick();
    checks++;
    if (oscillate !== 4'hF) begin
      errors++;
      $display("FAIL mid reset pre: osc=%h expected f", oscillate);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({oscillate, running, count_out} !== 24'h0) begin
      errors++;
      $display("FAIL mid reset: osc=%h run=%h cnt=%h expected all 0", oscillate, running, count_out);
    end
    reset = 1'b0;
    enable = '0;
  endtask
  initial begin
    test_reset();
    test_run();
    test_drain();
    test_reload();
    test_counters();
    test_independence();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
